cache_refill_axi_bridge: RTL and testbench
==========================================

Name: cache_refill_axi_bridge

Overview:
- Memory-side responder for the instruction cache's refill port.
- Accepts a line-read request (rd_req/rd_addr) and issues one AXI4 INCR read burst of 4x32-bit beats.
- Assembles the beats into a 128-bit line and returns it on ret_valid/ret_data using the cache's two-cycle return rule.
- Sits between the cache and the AXI interconnect; single outstanding request.

Parameters:
ARID_VAL, 4'd0, fixed ARID driven on every burst
RET_HOLD, 2, cycles ret_valid/ret_data are held (cache samples in Replace, consumes in Refill); must be 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
rd_req  in  1  cache line-read request, level, held until ret_valid seen
rd_addr  in  32  request address, any byte offset
ret_valid  out  1  line return valid
ret_data  out  128  returned line, word k at [32k+31:32k]
ret_err  out  1  pulses with first ret_valid cycle if the burst had a protocol/response error
arid  out  4  =ARID_VAL
araddr  out  32  {rd_addr[31:4],4'b0}
arlen  out  8  =8'd3
arsize  out  3  =3'b010
arburst  out  2  =2'b01
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rresp  in  2  R response
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (async assert, sync release): state IDLE; arvalid=0, rready=0, ret_valid=0, ret_err=0, ret_data=0, araddr=0, beat count=0, error flag=0. Constant outputs (arid/arlen/arsize/arburst) are always driven.
- States: IDLE, AR, R, RET0, RET1.
- IDLE: when rd_req=1, latch {rd_addr[31:4],4'b0} into araddr, clear the line buffer, beat count and error flag -> AR.
- AR: arvalid=1, araddr stable. On arvalid&arready -> R; arvalid drops the next cycle. No timeout.
- R: rready=1. Each rvalid&rready cycle:
  - write rdata into word[beat]; beat++.
  - set error flag if rresp!=2'b00.
  - set error flag if rlast is asserted while beat!=3; treat the burst as ended and leave the remaining words 0.
  - set error flag if beat==3 and rlast=0; the burst is still ended.
  - on an ending beat, go to RET0 (rready=0 from the next cycle).
- Beat count is 2 bits with no wrap beyond 3; the burst ends at most at beat 3.
- RET0: ret_valid=1, ret_data=assembled line, ret_err=error flag -> RET1.
- RET1: ret_valid=1, ret_data unchanged, ret_err=0 -> IDLE.
- ret_data is registered, stable through RET0/RET1, and holds its last value in IDLE.
- Latency with zero-wait AXI: request sampled at cycle t, arvalid at t+1, beats at t+2..t+5, ret_valid at t+6 and t+7.
- rd_req in AR/R/RET0/RET1 is ignored; no second request is queued.
- rd_req=1 in the first IDLE cycle after RET1 starts a new burst. The cache cannot legally do this; it is accepted anyway.
- rd_addr changes after acceptance are ignored.
- rvalid in IDLE/AR/RET*: rready=0, nothing is captured.
- Reset mid-burst: immediate return to reset values. Any in-flight AXI burst is abandoned; the system resets the interconnect together with this block.

Test Plan:
- Basic refill: rd_req=1, rd_addr=0x0000_1234; arready=1 immediately; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with rlast on beat 3 -> araddr=0x0000_1230, arlen=3, arsize=2, arburst=1; ret_data=0x44444444_33333333_22222222_11111111; ret_valid high exactly 2 cycles; ret_err=0.
- AR backpressure: arready low for 5 cycles -> arvalid held 6 cycles, araddr stable; rready=0 until the handshake; return data correct.
- R bubbles: rvalid toggling 1,0,0,1,0,1,1 -> words land in order; ret_valid 1 cycle after the 4th beat.
- Error response: beat 2 rresp=2'b10 -> all 4 words captured; ret_err=1 in RET0 only.
- Early rlast on beat 1 (data 0xA, 0xB) -> ret_data=0x0_0_B_A words; ret_err=1; next request afterwards completes normally.
- Reset mid-burst: rst=0 after beat 1 -> all outputs 0 asynchronously; after release, a new request at 0x8000_0010 yields araddr=0x8000_0010 and a clean return.

Source files
------------

// File: rtl/cache_refill_axi_bridge.sv
// Instruction-cache refill responder: turns one line-read request into a 4-beat
// AXI4 INCR read burst and returns the assembled 128-bit line for two cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for rd_req; ret_data holds the previous line
// S_AR   | arvalid high, waiting for arready
// S_R    | rready high, collecting beats into the line buffer
// S_RET0 | ret_valid high, ret_err reports the burst error flag
// S_RET1 | ret_valid high second cycle, ret_err low

module cache_refill_axi_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0,
    parameter int         RET_HOLD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [31:0]  rd_addr,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    output logic         ret_err,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RET0,
        S_RET1
    } state_t;

    state_t       state;
    logic [127:0] line;
    logic [127:0] line_next;
    logic [1:0]   beat;
    logic         err;
    logic         beat_fire;
    logic         beat_end;
    logic         beat_err;
    logic         unused_addr_bits;

    if (RET_HOLD != 2) begin : g_bad_ret_hold
        $error("cache_refill_axi_bridge: RET_HOLD must be 2");
    end

    assign arid    = ARID_VAL;
    assign arlen   = 8'd3;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Byte offset is dropped: the burst always starts on the line boundary.
    assign unused_addr_bits = ^rd_addr[3:0];

    assign beat_fire = rready && rvalid;
    assign beat_end  = rlast || (beat == 2'd3);
    // rlast must coincide exactly with the fourth beat; either mismatch is an error.
    assign beat_err  = (rresp != 2'b00) || (rlast != (beat == 2'd3));

    always_comb begin
        line_next = line;
        line_next[{beat, 5'd0} +: 32] = rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            arvalid   <= 1'b0;
            araddr    <= '0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            ret_err   <= 1'b0;
            ret_data  <= '0;
            line      <= '0;
            beat      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ret_valid <= 1'b0;
                    ret_err   <= 1'b0;
                    if (rd_req) begin
                        araddr  <= {rd_addr[31:4], 4'b0000};
                        line    <= '0;
                        beat    <= '0;
                        err     <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (beat_fire) begin
                        line <= line_next;
                        err  <= err || beat_err;
                        if (beat_end) begin
                            rready    <= 1'b0;
                            ret_valid <= 1'b1;
                            ret_data  <= line_next;
                            ret_err   <= err || beat_err;
                            state     <= S_RET0;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                S_RET0: begin
                    ret_valid <= 1'b1;
                    ret_err   <= 1'b0;
                    state     <= S_RET1;
                end
                S_RET1: begin
                    ret_valid <= 1'b0;
                    ret_err   <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                    ret_valid <= 1'b0;
                    ret_err   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_axi_bridge.sv
// Bench for cache_refill_axi_bridge: an AXI read-slave driver feeds directed and
// random bursts; a monitor checks AR requests and line returns against queued expectations.

module tb_cache_refill_axi_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_req = 1'b0;
    logic [31:0]  rd_addr = '0;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic         ret_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;

    always #5 clk = ~clk;

    cache_refill_axi_bridge #(.ARID_VAL(4'd0), .RET_HOLD(2)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int errors = 0;
    int checks = 0;
    bit stopped = 0;

    typedef struct { logic [127:0] line; logic err; } ret_t;
    typedef struct { logic [31:0] addr; int dly; } ar_t;
    ret_t ret_q[$];
    ar_t  ar_q[$];

    // Transaction description used by the driver and the reference model.
    logic [31:0] t_data[4];
    logic [1:0]  t_resp[4];
    int          t_gap[4];
    int          t_nbeats;
    bit          t_rlast_last;
    int          t_ar_dly;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: got no DUT response expected one within budget", name);
        if (!stopped) begin
            stopped = 1;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    // Expected line: each delivered beat lands in its word slot, undelivered words
    // stay zero; any non-OKAY response or misplaced/missing rlast flags an error.
    function automatic ret_t model();
        ret_t r;
        r.line = '0;
        r.err  = 1'b0;
        for (int k = 0; k < t_nbeats; k++) begin
            r.line[32*k +: 32] = t_data[k];
            if (t_resp[k] != 2'b00) r.err = 1'b1;
        end
        if (t_nbeats < 4 || !t_rlast_last) r.err = 1'b1;
        return r;
    endfunction

    task automatic set_basic();
        for (int k = 0; k < 4; k++) begin
            t_data[k] = $urandom;
            t_resp[k] = 2'b00;
            t_gap[k]  = 0;
        end
        t_nbeats     = 4;
        t_rlast_last = 1;
        t_ar_dly     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_ret_valid"}, ret_valid, 1'b0);
        chk({tag, "_ret_err"}, ret_err, 1'b0);
        chk({tag, "_ret_data"}, ret_data, 128'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_consts"}, {arid, arlen, arsize, arburst}, {4'd0, 8'd3, 3'b010, 2'b01});
    endtask

    task automatic do_txn(input logic [31:0] addr, input int abort_at);
        ar_t a;
        int  n;
        a.addr = {addr[31:4], 4'b0000};
        a.dly  = t_ar_dly;
        ar_q.push_back(a);
        ret_q.push_back(model());

        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = addr;
        arready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            rvalid = 1'($urandom_range(0, 1));
            rdata  = $urandom;
            rlast  = 1'($urandom_range(0, 1));
            n++;
        end while (!arvalid && n < 20);
        if (!arvalid) begin
            fail_timeout("arvalid");
            return;
        end
        rd_addr = $urandom;
        repeat (t_ar_dly) begin
            @(negedge clk);
            rvalid = 1'($urandom_range(0, 1));
            rdata  = $urandom;
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;

        for (int k = 0; k < t_nbeats; k++) begin
            repeat (t_gap[k]) begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rlast  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            rvalid = 1'b1;
            rdata  = t_data[k];
            rresp  = t_resp[k];
            rlast  = (k == t_nbeats - 1) && t_rlast_last;
            chk("rready_in_burst", rready, 1'b1);
            if (abort_at == k) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1;
                check_reset_outputs("midreset");
                rvalid = 1'b0;
                rd_req = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                ret_q.delete();
                ar_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (k < t_nbeats - 1) @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk("ret_valid_after_last_beat", ret_valid, 1'b1);
        chk("rready_after_last_beat", rready, 1'b0);
        @(negedge clk);
        rd_req = 1'b0;
        rvalid = 1'($urandom_range(0, 1));
        rresp  = 2'b00;
        rlast  = 1'b0;
        rdata  = $urandom;
    endtask

    // Monitor: checks every AR request and every line return as the DUT presents them.
    initial begin
        ar_t  cur_ar;
        ret_t cur_ret;
        int   av_run;
        int   rv_run;
        cur_ar.addr  = '0;
        cur_ar.dly   = 0;
        cur_ret.line = '0;
        cur_ret.err  = 1'b0;
        av_run = 0;
        rv_run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                av_run = 0;
                rv_run = 0;
                continue;
            end
            if (arvalid) begin
                if (av_run == 0) begin
                    if (ar_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ar: got arvalid with araddr %h expected no request", araddr);
                    end else begin
                        cur_ar = ar_q.pop_front();
                        chk("araddr", araddr, cur_ar.addr);
                        chk("ar_consts", {arid, arlen, arsize, arburst}, {4'd0, 8'd3, 3'b010, 2'b01});
                    end
                end else begin
                    chk("araddr_stable", araddr, cur_ar.addr);
                end
                chk("rready_during_ar", rready, 1'b0);
                av_run++;
            end else if (av_run != 0) begin
                chk("arvalid_cycles", av_run, cur_ar.dly + 1);
                av_run = 0;
            end
            if (ret_valid) begin
                if (rv_run == 0) begin
                    if (ret_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ret: got ret_valid with data %h expected none", ret_data);
                    end else begin
                        cur_ret = ret_q.pop_front();
                        chk("ret_data", ret_data, cur_ret.line);
                        chk("ret_err_first", ret_err, cur_ret.err);
                    end
                end else begin
                    chk("ret_data_hold", ret_data, cur_ret.line);
                    chk("ret_err_second", ret_err, 1'b0);
                end
                rv_run++;
            end else if (rv_run != 0) begin
                chk("ret_valid_cycles", rv_run, 2);
                rv_run = 0;
            end
        end
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic refill
        set_basic();
        t_data[0] = 32'h11111111;
        t_data[1] = 32'h22222222;
        t_data[2] = 32'h33333333;
        t_data[3] = 32'h44444444;
        do_txn(32'h0000_1234, -1);
        repeat (3) @(negedge clk);
        chk("ret_data_idle_hold", ret_data, 128'h44444444_33333333_22222222_11111111);

        // AR backpressure
        set_basic();
        t_ar_dly = 5;
        do_txn(32'h0000_ABC8, -1);

        // R bubbles 1,0,0,1,0,1,1
        set_basic();
        t_gap[0] = 0;
        t_gap[1] = 2;
        t_gap[2] = 1;
        t_gap[3] = 0;
        do_txn(32'h1000_0004, -1);

        // Error response on beat 2
        set_basic();
        t_resp[2] = 2'b10;
        do_txn(32'h2000_0020, -1);

        // Early rlast on beat 1, then a normal request
        set_basic();
        t_data[0]    = 32'h0000000A;
        t_data[1]    = 32'h0000000B;
        t_nbeats     = 2;
        t_rlast_last = 1;
        do_txn(32'h3000_0030, -1);
        set_basic();
        do_txn(32'h3000_0040, -1);

        // Missing rlast on the fourth beat
        set_basic();
        t_rlast_last = 0;
        do_txn(32'h4000_0050, -1);

        // Reset mid-burst, then a clean request
        set_basic();
        do_txn(32'h5000_0060, 1);
        set_basic();
        do_txn(32'h8000_0010, -1);

        for (int i = 0; i < 40; i++) begin
            int m;
            set_basic();
            for (int k = 0; k < 4; k++) begin
                t_resp[k] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                t_gap[k]  = $urandom_range(0, 2);
            end
            m = $urandom_range(0, 7);
            if (m == 6) begin
                t_nbeats = $urandom_range(1, 3);
            end else if (m == 7) begin
                t_rlast_last = 0;
            end
            t_ar_dly = $urandom_range(0, 3);
            do_txn($urandom, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        chk("ar_queue_drained", ar_q.size(), 0);
        chk("ret_queue_drained", ret_q.size(), 0);
        if (!stopped) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        fail_timeout("global");
    end

endmodule
